// File: rtl/soda_pkg.sv
// Shared encodings for the soda dispense arbiter.
// Optional build macro SODA_ARB_JAM_EN adds the FAULT state.
package soda_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    PULSE = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
`ifdef SODA_ARB_JAM_EN
    ,
    FAULT = 3'd5
`endif
  } soda_state_e;

  typedef enum logic {
    TYPE_SODA = 1'b0,
    TYPE_COIN = 1'b1
  } soda_type_e;

  localparam int SODA_PULSE_DEFAULT = 4;
  localparam int SODA_GAP_DEFAULT   = 2;

endpackage

// File: rtl/soda_rr_picker.sv
// Round-robin requester picker: searches from the requester after the last
// one served and returns the first active request as one-hot and as index.
module soda_rr_picker #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last,
  output logic [N_REQ-1:0]         pick,
  output logic [$clog2(N_REQ)-1:0] idx,
  output logic                     valid
);

  localparam int IW = $clog2(N_REQ);

  // Walk the requesters in rotating order, keep the first hit
  always_comb begin
    int cand;
    cand  = 0;
    pick  = '0;
    idx   = '0;
    valid = 1'b0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand = (int'(last) + off) % N_REQ;
      if (!valid && req[cand]) begin
        valid      = 1'b1;
        pick[cand] = 1'b1;
        idx        = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/soda_dispense_arbiter.sv
// Shares one dispense mechanism (soda motor / coin-return motor) between
// N_REQ vending front-ends. Each job drives PULSE_CYCLES motor-on cycles per
// unit with GAP_CYCLES off between units, then pulses the requester's grant.
// Optional build macro SODA_ARB_JAM_EN adds a jam input, a fault output and a
// latching FAULT state left only by reset.
module soda_dispense_arbiter
  import soda_pkg::*;
#(
  parameter int N_REQ        = 2,
  parameter int PULSE_CYCLES = SODA_PULSE_DEFAULT,
  parameter int GAP_CYCLES   = SODA_GAP_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   req_type,
  input  logic [2*N_REQ-1:0] req_count,
`ifdef SODA_ARB_JAM_EN
  input  logic               jam,
`endif
  output logic [N_REQ-1:0]   grant,
  output logic               motor_soda,
  output logic               motor_coin,
  output logic               busy,
`ifdef SODA_ARB_JAM_EN
  output logic               fault,
`endif
  output logic [2:0]         state_display
);

  localparam int IW = $clog2(N_REQ);
  localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYCLES - 1);
  localparam logic [3:0] GAP_LAST   = 4'(GAP_CYCLES - 1);

  soda_state_e      state_q, state_d;
  logic [IW-1:0]    last_q, last_d;
  logic [IW-1:0]    job_idx_q, job_idx_d;
  logic [N_REQ-1:0] job_pick_q, job_pick_d;
  soda_type_e       job_type_q, job_type_d;
  logic [1:0]       units_q, units_d;
  logic [3:0]       cyc_q, cyc_d;

  logic [N_REQ-1:0] pick;
  logic [IW-1:0]    pick_idx;
  logic             pick_vld;
  logic [1:0]       cnt_sel;

  logic [N_REQ-1:0] grant_d;
  logic             motor_soda_d, motor_coin_d, busy_d;
`ifdef SODA_ARB_JAM_EN
  logic             fault_d;
`endif

  soda_rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req   (req),
    .last  (last_q),
    .pick  (pick),
    .idx   (pick_idx),
    .valid (pick_vld)
  );

  assign cnt_sel = req_count[{pick_idx, 1'b0} +: 2];

  // Next-state, job latching and next-cycle output values
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    job_idx_d  = job_idx_q;
    job_pick_d = job_pick_q;
    job_type_d = job_type_q;
    units_d    = units_q;
    cyc_d      = cyc_q;
    case (state_q)
      IDLE: begin
        if (|req) state_d = LOAD;
      end
      LOAD: begin
        // A requester may have dropped between IDLE and LOAD; fall back.
        if (pick_vld) begin
          job_idx_d  = pick_idx;
          job_pick_d = pick;
          job_type_d = soda_type_e'(req_type[pick_idx]);
          units_d    = (cnt_sel == 2'd0) ? 2'd1 : cnt_sel;
          cyc_d      = '0;
          state_d    = PULSE;
        end else begin
          state_d = IDLE;
        end
      end
      PULSE: begin
`ifdef SODA_ARB_JAM_EN
        if (jam) begin
          state_d = FAULT;
        end else
`endif
        if (cyc_q == PULSE_LAST) begin
          cyc_d   = '0;
          units_d = units_q - 2'd1;
          state_d = (units_q == 2'd1) ? DONE : GAP;
        end else begin
          cyc_d = cyc_q + 4'd1;
        end
      end
      GAP: begin
        if (cyc_q == GAP_LAST) begin
          cyc_d   = '0;
          state_d = PULSE;
        end else begin
          cyc_d = cyc_q + 4'd1;
        end
      end
      DONE: begin
        last_d  = job_idx_q;
        state_d = IDLE;
      end
`ifdef SODA_ARB_JAM_EN
      FAULT: begin
        state_d = FAULT;
      end
`endif
      default: state_d = IDLE;
    endcase

    motor_soda_d = (state_d == PULSE) && (job_type_d == TYPE_SODA);
    motor_coin_d = (state_d == PULSE) && (job_type_d == TYPE_COIN);
    grant_d      = (state_d == DONE) ? job_pick_d : '0;
    busy_d       = (state_d != IDLE);
`ifdef SODA_ARB_JAM_EN
    fault_d      = (state_d == FAULT);
`endif
  end

  // Control state and registered outputs, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      last_q     <= IW'(N_REQ - 1);
      grant      <= '0;
      motor_soda <= 1'b0;
      motor_coin <= 1'b0;
      busy       <= 1'b0;
`ifdef SODA_ARB_JAM_EN
      fault      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      grant      <= grant_d;
      motor_soda <= motor_soda_d;
      motor_coin <= motor_coin_d;
      busy       <= busy_d;
`ifdef SODA_ARB_JAM_EN
      fault      <= fault_d;
`endif
    end
  end

  // Job payload: only meaningful after LOAD, so no reset needed
  always_ff @(posedge clk) begin
    job_idx_q  <= job_idx_d;
    job_pick_q <= job_pick_d;
    job_type_q <= job_type_d;
    units_q    <= units_d;
    cyc_q      <= cyc_d;
  end

  assign state_display = state_q;

endmodule

// File: doc/soda_dispense_arbiter.md
SODA_DISPENSE_ARBITER -- requirements
Module: soda_dispense_arbiter

Interface
REQ-001 Parameter N_REQ, default 2, number of vending front-ends sharing one dispense mechanism (2..4).
REQ-002 Parameter PULSE_CYCLES, default 4, motor-on cycles per dispensed unit (1..15).
REQ-003 Parameter GAP_CYCLES, default 2, motor-off cycles between consecutive units (1..15).
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  N_REQ  per-requester service request, level, held until granted.
REQ-007 req_type  input  N_REQ  per-requester unit kind: 0 = soda, 1 = coin return.
REQ-008 req_count  input  2*N_REQ  per-requester unit count, 2 bits each (requester i at bits 2i+1:2i); 0 treated as 1.
REQ-009 grant  output  N_REQ  one-hot; one-cycle pulse to the served requester when its job completes.
REQ-010 motor_soda  output  1  soda dispense motor drive.
REQ-011 motor_coin  output  1  coin return motor drive.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 state_display  output  3  current state encoding.

Function
REQ-014 States SHALL be IDLE=0, LOAD=1, PULSE=2, GAP=3, DONE=4; all outputs registered.
REQ-015 IDLE: if any req bit high, SHALL go to LOAD next cycle; else stay.
REQ-016 LOAD: SHALL pick requester by round-robin starting at (last served + 1) mod N_REQ, latch its index, req_type and effective count, and go to PULSE.
REQ-017 PULSE: motor_soda (type 0) or motor_coin (type 1) SHALL be high for exactly PULSE_CYCLES cycles, then count decrements.
REQ-018 After PULSE: remaining count > 0 -> GAP; remaining count = 0 -> DONE.
REQ-019 GAP: both motors low for exactly GAP_CYCLES cycles, then PULSE.
REQ-020 DONE: grant bit of latched requester SHALL be high for exactly one cycle; round-robin pointer updates to latched index; next state IDLE.
REQ-021 At most one motor SHALL be high in any cycle; grant SHALL be zero or one-hot.
REQ-022 Latched type/count SHALL NOT change during a job even if req_type/req_count change.
REQ-023 Requester dropping req mid-job SHALL NOT abort the job; its grant still pulses.
REQ-024 Requester still asserting req after its grant is eligible again only via round-robin order.
REQ-025 Simultaneous requests: no requester SHALL wait more than N_REQ-1 other jobs.

Reset
REQ-026 reset high at any clock edge SHALL force IDLE, motors low, grant 0, busy 0, state_display 0, pointer so requester 0 has highest priority next.
REQ-027 reset mid-PULSE SHALL drop the motor on the following edge; aborted job receives no grant.

Configuration
REQ-028 Macro SODA_ARB_JAM_EN SHALL add input jam (1 bit) and output fault (1 bit), plus state FAULT=5.
REQ-029 With SODA_ARB_JAM_EN: jam high in PULSE SHALL enter FAULT next cycle; FAULT holds motors low, fault high, no grant, exit only by reset.
REQ-030 Without SODA_ARB_JAM_EN: ports jam/fault and state FAULT SHALL not exist; behaviour otherwise identical.

Structure
REQ-031 Package soda_pkg SHALL hold state encodings, req_type encodings and default PULSE/GAP constants.
REQ-032 Round-robin selection SHALL be a sub-module soda_rr_picker (combinational: req, pointer -> one-hot pick, index).

Verification
REQ-033 Single req[0], type 0, count 1 -> motor_soda high 4 cycles, grant=01 one cycle after, busy low after DONE.
REQ-034 req[1], type 1, count 3 -> motor_coin pattern 4 on / 2 off / 4 on / 2 off / 4 on, then grant=10.
REQ-035 req=11 held continuously after reset -> grants alternate 01, 10, 01, 10.
REQ-036 count 0 request -> exactly one unit dispensed.
REQ-037 reset asserted during second PULSE of count-3 job -> motors low next edge, state_display 0, no grant.
REQ-038 With SODA_ARB_JAM_EN, jam pulsed during PULSE -> state 5, fault=1, motors 0 until reset.
